// File: rtl/dcache_pkg.sv
// Shared types and default sizes for the write-through data cache.
// Also holds a saturating increment helper used by the hit and miss counters.
package dcache_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IDX_W_DEF  = 4;
  localparam int unsigned TAG_W_DEF  = ADDR_W_DEF - IDX_W_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side (MEM stage) and memory-side buses of the data cache.
// In both buses the master drives the request.
interface dcache_cpu_if import dcache_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata,
                  input  cpu_rdata, cpu_stall);
  modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
                  output cpu_rdata, cpu_stall);
endinterface

interface dcache_mem_if import dcache_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/dcache_store.sv
// Tag/data/valid arrays: combinational lookup, one write port, invalidate-all.
// Only the valid bits are reset; tag and data contents are don't-care until filled.
module dcache_store import dcache_pkg::*; #(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [TAG_W-1:0]  rd_tag_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              inval_i
);
  localparam int unsigned LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (inval_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage
// and data memory. Read hits complete in the request cycle; misses and stores stall.
module dcache_wt import dcache_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  dcache_cpu_if.slave        cpu,
  dcache_mem_if.master       mem,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              fill_done_q, fill_done_d;
  logic              wr_done_q, wr_done_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [DATA_W-1:0] line_data;
  logic              st_we;
  logic [DATA_W-1:0] st_wdata;
  logic              flush_eff;
  logic              is_idle;
  logic              rd_hit, rd_miss, wr_issue;

  assign idx = cpu.cpu_addr[IDX_W-1:0];
  assign tag = cpu.cpu_addr[ADDR_W-1:IDX_W];

  dcache_store #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk_i     (clock),
    .rst_ni    (reset),
    .rd_idx_i  (idx),
    .rd_tag_i  (tag),
    .hit_o     (hit),
    .rd_data_o (line_data),
    .we_i      (st_we),
    .wr_idx_i  (idx),
    .wr_tag_i  (tag),
    .wr_data_i (st_wdata),
    .inval_i   (flush_eff)
  );

  assign is_idle   = (state_q == IDLE);
  // A pending flush acts exactly like a live flush pulse on the first IDLE cycle.
  assign flush_eff = is_idle && (flush || flush_pend_q);
  assign rd_hit    = is_idle && cpu.cpu_req && !cpu.cpu_we && hit && !flush_eff;
  assign rd_miss   = is_idle && cpu.cpu_req && !cpu.cpu_we && !(hit && !flush_eff);
  // The store just written through is still presented during its replay cycle.
  assign wr_issue  = is_idle && cpu.cpu_req && cpu.cpu_we && !wr_done_q;

  assign st_wdata  = (state_q == RD_MISS) ? mem.mem_rdata : cpu.cpu_wdata;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    flush_pend_d = flush_pend_q;
    fill_done_d  = 1'b0;
    wr_done_d    = 1'b0;
    st_we        = 1'b0;
    case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (rd_hit && !fill_done_q) begin
          hit_cnt_d = sat_inc16(hit_cnt_q);
        end
        if (rd_miss) begin
          miss_cnt_d = sat_inc16(miss_cnt_q);
          state_d    = RD_MISS;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = cpu.cpu_addr;
        end else if (wr_issue) begin
          state_d     = WR_THRU;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = cpu.cpu_addr;
          mem_wdata_d = cpu.cpu_wdata;
        end
      end
      RD_MISS: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem.mem_ack) begin
          st_we       = 1'b1;
          mem_req_d   = 1'b0;
          fill_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      WR_THRU: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem.mem_ack) begin
          st_we     = hit;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wr_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      fill_done_q  <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      flush_pend_q <= flush_pend_d;
      fill_done_q  <= fill_done_d;
      wr_done_q    <= wr_done_d;
    end
  end

  // Stall and read data are forced quiet while reset is held low.
  assign cpu.cpu_stall = reset && (rd_miss || wr_issue || !is_idle);
  assign cpu.cpu_rdata = (reset && rd_hit) ? line_data : '0;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: transaction-level cache/memory model plus a
// per-cycle compare process, with literal expectations from the test plan.
module tb_dcache_wt;
  import dcache_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] hit_cnt, miss_cnt;

  dcache_cpu_if #(.ADDR_W(AW), .DATA_W(DW)) cbus ();
  dcache_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mbus ();

  dcache_wt #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .cpu      (cbus),
    .mem      (mbus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backing memory and responder: ack on the lat-th cycle mem_req is seen high.
  logic [15:0] mem_model [256];
  int unsigned lat = 2;
  bit          stray_ack = 1'b0;
  int unsigned req_cyc = 0;

  initial begin
    mbus.mem_ack   = 1'b0;
    mbus.mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      mbus.mem_ack = 1'b0;
      if (!reset || !mbus.mem_req) begin
        req_cyc = 0;
      end else begin
        req_cyc++;
        if (req_cyc == lat) begin
          mbus.mem_ack = 1'b1;
          if (mbus.mem_we) mem_model[mbus.mem_addr] = mbus.mem_wdata;
          else             mbus.mem_rdata = mem_model[mbus.mem_addr];
        end
      end
      if (stray_ack) mbus.mem_ack = 1'b1;
    end
  end

  // Cache contents model: which tag each line holds, if any.
  bit         mvalid [16];
  logic [3:0] mtag   [16];
  int         exp_hit  = 0;
  int         exp_miss = 0;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  // Per-cycle invariants: a completed load returns memory contents; the memory
  // request mirrors the stalled access; nothing is requested while not stalled.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (cbus.cpu_req && !cbus.cpu_we && !cbus.cpu_stall)
          chk("rdata_vs_mem", 32'(cbus.cpu_rdata), 32'(mem_model[cbus.cpu_addr]));
        if (!cbus.cpu_stall)
          chk("req_while_free", 32'(mbus.mem_req), 32'd0);
        if (mbus.mem_req) begin
          chk("mem_addr", 32'(mbus.mem_addr), 32'(cbus.cpu_addr));
          chk("mem_we", 32'(mbus.mem_we), 32'(cbus.cpu_we));
          if (mbus.mem_we) chk("mem_wdata", 32'(mbus.mem_wdata), 32'(cbus.cpu_wdata));
        end
      end
    end
  end

  // flush_mode: 0 none, 1 pulse with the request, 2 pulse in the cycle after issue.
  task automatic access(input bit we, input logic [7:0] addr, input logic [15:0] wdata,
                        input int flush_mode, output logic [15:0] rd, output logic [15:0] wd,
                        output int stalls, output bit saw_req);
    bit done = 1'b0;
    cbus.cpu_req   = 1'b1;
    cbus.cpu_we    = we;
    cbus.cpu_addr  = addr;
    cbus.cpu_wdata = wdata;
    flush          = (flush_mode == 1);
    stalls = 0; saw_req = 1'b0; rd = '0; wd = '0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clock);
      if (mbus.mem_req) saw_req = 1'b1;
      if (mbus.mem_req && mbus.mem_we) wd = mbus.mem_wdata;
      if (!cbus.cpu_stall) begin
        done = 1'b1;
        rd   = cbus.cpu_rdata;
      end else begin
        stalls++;
      end
      @(posedge clock);
      #1;
      flush = (flush_mode == 2 && c == 0);
    end
    flush        = 1'b0;
    cbus.cpu_req = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL stall_bound: access %h still stalled after 64 cycles", addr);
    end
  endtask

  task automatic do_acc(input bit we, input logic [7:0] addr, input logic [15:0] wdata,
                        input int flush_mode, output logic [15:0] rd, output logic [15:0] wd);
    int         stalls, exp_st;
    bit         saw_req, exp_req;
    logic [3:0] ix, tg;
    ix = addr[3:0];
    tg = addr[7:4];
    if (flush_mode == 1) for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    if (we) begin
      exp_st  = int'(lat) + 1;
      exp_req = 1'b1;
    end else if (mvalid[ix] && mtag[ix] == tg) begin
      exp_hit++;
      exp_st  = 0;
      exp_req = 1'b0;
    end else begin
      exp_miss++;
      exp_st  = int'(lat) + 1;
      exp_req = 1'b1;
      if (flush_mode == 2) begin
        // The fill lands, the deferred flush wipes it, and the replay misses again.
        exp_miss++;
        exp_st = 2 * (int'(lat) + 1);
      end
      for (int i = 0; i < 16; i++) if (flush_mode == 2) mvalid[i] = 1'b0;
      mvalid[ix] = 1'b1;
      mtag[ix]   = tg;
    end
    access(we, addr, wdata, flush_mode, rd, wd, stalls, saw_req);
    chk("stall_cycles", 32'(stalls), 32'(exp_st));
    chk("mem_req_seen", 32'(saw_req), 32'(exp_req));
    chk("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
    chk("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
  endtask

  initial begin
    logic [15:0] rd, wd;
    for (int i = 0; i < 256; i++) mem_model[i] = 16'h4000 + 16'(i * 7);
    mem_model[0] = 16'h13ab;
    cbus.cpu_req = 1'b0; cbus.cpu_we = 1'b0; cbus.cpu_addr = '0; cbus.cpu_wdata = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_mem_req", 32'(mbus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(mbus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mbus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mbus.mem_wdata), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_stall", 32'(cbus.cpu_stall), 32'd0);
    chk("rst_rdata", 32'(cbus.cpu_rdata), 32'd0);
    @(posedge clock); #1;

    lat = 2;
    do_acc(0, 8'h00, 16'h0, 0, rd, wd);
    chk("lit_first_rdata", 32'(rd), 32'h13ab);
    chk("lit_first_miss", 32'(miss_cnt), 32'd1);
    chk("lit_first_hit", 32'(hit_cnt), 32'd0);
    do_acc(0, 8'h00, 16'h0, 0, rd, wd);
    chk("lit_rehit_rdata", 32'(rd), 32'h13ab);
    chk("lit_rehit_cnt", 32'(hit_cnt), 32'd1);
    do_acc(1, 8'h00, 16'h2799, 0, rd, wd);
    chk("lit_store_wdata", 32'(wd), 32'h2799);
    do_acc(0, 8'h00, 16'h0, 0, rd, wd);
    chk("lit_store_update", 32'(rd), 32'h2799);
    lat = 3;
    do_acc(1, 8'h31, 16'hbeef, 0, rd, wd);
    chk("lit_wmiss_mem", 32'(mem_model[8'h31]), 32'hbeef);
    do_acc(0, 8'h31, 16'h0, 0, rd, wd);
    chk("lit_no_alloc_miss", 32'(miss_cnt), 32'd2);
    chk("lit_wmiss_rdata", 32'(rd), 32'hbeef);
    lat = 1;
    do_acc(0, 8'h10, 16'h0, 0, rd, wd);
    do_acc(0, 8'h00, 16'h0, 0, rd, wd);
    chk("lit_conflict_miss", 32'(miss_cnt), 32'd4);
    chk("lit_conflict_rdata", 32'(rd), 32'h2799);

    // A stray ack while idle must change nothing.
    @(negedge clock) stray_ack = 1'b1;
    @(negedge clock) stray_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    do_acc(0, 8'h00, 16'h0, 0, rd, wd);

    lat = 2;
    do_acc(0, 8'h00, 16'h0, 1, rd, wd);
    do_acc(0, 8'h02, 16'h0, 2, rd, wd);
    do_acc(0, 8'h00, 16'h0, 0, rd, wd);
    do_acc(0, 8'h02, 16'h0, 0, rd, wd);
    do_acc(1, 8'h02, 16'h5a5a, 0, rd, wd);
    do_acc(0, 8'h02, 16'h0, 0, rd, wd);
    chk("lit_flush_seq_hits", 32'(hit_cnt), 32'd5);

    // Reset during an outstanding fill.
    lat = 6;
    cbus.cpu_req = 1'b1; cbus.cpu_we = 1'b0; cbus.cpu_addr = 8'h05;
    @(negedge clock);
    @(negedge clock);
    chk("mid_req_up", 32'(mbus.mem_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_mem_req", 32'(mbus.mem_req), 32'd0);
    chk("async_stall", 32'(cbus.cpu_stall), 32'd0);
    chk("async_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("async_miss_cnt", 32'(miss_cnt), 32'd0);
    cbus.cpu_req = 1'b0;
    model_reset();
    @(posedge clock); #1 reset = 1'b1;
    lat = 2;
    do_acc(0, 8'h00, 16'h0, 0, rd, wd);
    chk("lit_post_rst_miss", 32'(miss_cnt), 32'd1);

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
